// File: rtl/e1_pkg.sv
// Shared constants and types for the E1 tributary scheduler.
// Optional build macro used by e1_trib_sched: E1SCHED_AISINS_EN.
package e1_pkg;

    localparam int         E1_NTRIB    = 21;
    localparam int         E1_WID      = 8;
    localparam int         E1_TIDW     = 5;
    localparam logic [7:0] E1_AIS_BYTE = 8'hFF;

    typedef enum logic {
        OST_EMPTY = 1'b0,
        OST_FULL  = 1'b1
    } ost_t;

endpackage

// File: rtl/e1_rr_arb.sv
// Combinational round-robin priority encoder: searches pend starting one above rr_ptr, wrapping at NTRIB-1.
// The pointer register itself lives in the parent.
module e1_rr_arb
    import e1_pkg::*;
#(
    parameter int NTRIB = E1_NTRIB,
    parameter int TIDW  = E1_TIDW
) (
    input  logic [NTRIB-1:0] pend,
    input  logic [TIDW-1:0]  rr_ptr,
    output logic             gnt_vld,
    output logic [TIDW-1:0]  gnt_idx
);

    logic [TIDW-1:0] idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NTRIB; k++) begin
            idx = TIDW'((int'(rr_ptr) + k) % NTRIB);
            if (!gnt_vld && pend[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/e1_trib_sched.sv
// Round-robin scheduler sharing one VT mapper write port among NTRIB E1 framers.
// Build macro E1SCHED_AISINS_EN: when defined, bytes captured during AIS are replaced by the all-ones pattern.
module e1_trib_sched
    import e1_pkg::*;
#(
    parameter int NTRIB = E1_NTRIB,
    parameter int WID   = E1_WID,
    parameter int TIDW  = E1_TIDW
) (
    input  logic                 clk19,
    input  logic                 rst,
    input  logic [NTRIB-1:0]     trib_en,
    input  logic [NTRIB*WID-1:0] rx_dat,
    input  logic [NTRIB-1:0]     rx_vld,
    input  logic [NTRIB-1:0]     rx_ais,
    output logic [WID-1:0]       map_dat,
    output logic [TIDW-1:0]      map_tid,
    output logic                 map_ais,
    output logic                 map_vld,
    input  logic                 map_rdy,
    output logic [NTRIB-1:0]     ovf,
    input  logic [NTRIB-1:0]     ovf_clr
);

    logic [WID-1:0]   slot_dat [NTRIB];
    logic [NTRIB-1:0] slot_ais;
    logic [NTRIB-1:0] pend;
    logic [TIDW-1:0]  rr_ptr;
    logic [TIDW-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             take;
    logic [NTRIB-1:0] gnt_oh;
    logic [NTRIB-1:0] cap;
    logic [NTRIB-1:0] ovf_set;
    ost_t             ost;
    ost_t             ost_nxt;

    // Disabled tribs are masked here so a slot being cleared this cycle cannot win.
    e1_rr_arb #(
        .NTRIB (NTRIB),
        .TIDW  (TIDW)
    ) u_arb (
        .pend    (pend & trib_en),
        .rr_ptr  (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // A slot being granted this cycle frees up in time to take a same-cycle byte.
    assign gnt_oh  = take ? (NTRIB'(1) << gnt_idx) : '0;
    assign cap     = rx_vld & trib_en & (~pend | gnt_oh);
    assign ovf_set = rx_vld & trib_en & pend & ~gnt_oh;

    always_ff @(posedge clk19 or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            slot_ais <= '0;
            for (int i = 0; i < NTRIB; i++) begin
                slot_dat[i] <= '0;
            end
        end else begin
            pend <= trib_en & (cap | (pend & ~gnt_oh));
            for (int i = 0; i < NTRIB; i++) begin
                if (cap[i]) begin
`ifdef E1SCHED_AISINS_EN
                    slot_dat[i] <= rx_ais[i] ? WID'(E1_AIS_BYTE) : rx_dat[i*WID +: WID];
`else
                    slot_dat[i] <= rx_dat[i*WID +: WID];
`endif
                    slot_ais[i] <= rx_ais[i];
                end
            end
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk19 or negedge rst) begin
        if (!rst) begin
            ovf <= '0;
        end else begin
            ovf <= ovf_set | (ovf & ~ovf_clr);
        end
    end

    always_ff @(posedge clk19 or negedge rst) begin
        if (!rst) begin
            ost <= OST_EMPTY;
        end else begin
            ost <= ost_nxt;
        end
    end

    always_comb begin
        ost_nxt = ost;
        case (ost)
            OST_EMPTY: if (gnt_vld) ost_nxt = OST_FULL;
            OST_FULL:  if (map_rdy) ost_nxt = gnt_vld ? OST_FULL : OST_EMPTY;
            default:   ost_nxt = OST_EMPTY;
        endcase
    end

    always_comb begin
        map_vld = (ost == OST_FULL);
        take    = gnt_vld && ((ost == OST_EMPTY) || map_rdy);
    end

    always_ff @(posedge clk19 or negedge rst) begin
        if (!rst) begin
            map_dat <= '0;
            map_tid <= '0;
            map_ais <= 1'b0;
            rr_ptr  <= TIDW'(NTRIB - 1);
        end else if (take) begin
            map_dat <= slot_dat[gnt_idx];
            map_tid <= gnt_idx;
            map_ais <= slot_ais[gnt_idx];
            rr_ptr  <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_e1_trib_sched.sv
// Scoreboard bench for e1_trib_sched: a reference model predicts delivered bytes and overflow flags,
// a monitor compares every mapper transfer and the ovf vector each cycle.
module tb_e1_trib_sched;
    import e1_pkg::*;

    localparam int NT = E1_NTRIB;
    localparam int W  = E1_WID;
    localparam int TW = E1_TIDW;
`ifdef E1SCHED_AISINS_EN
    localparam bit AISINS = 1'b1;
`else
    localparam bit AISINS = 1'b0;
`endif

    logic            clk19 = 1'b0;
    logic            rst   = 1'b0;
    logic [NT-1:0]   trib_en;
    logic [NT*W-1:0] rx_dat;
    logic [NT-1:0]   rx_vld;
    logic [NT-1:0]   rx_ais;
    logic [W-1:0]    map_dat;
    logic [TW-1:0]   map_tid;
    logic            map_ais;
    logic            map_vld;
    logic            map_rdy;
    logic [NT-1:0]   ovf;
    logic [NT-1:0]   ovf_clr;

    e1_trib_sched dut (
        .clk19   (clk19),
        .rst     (rst),
        .trib_en (trib_en),
        .rx_dat  (rx_dat),
        .rx_vld  (rx_vld),
        .rx_ais  (rx_ais),
        .map_dat (map_dat),
        .map_tid (map_tid),
        .map_ais (map_ais),
        .map_vld (map_vld),
        .map_rdy (map_rdy),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk19 = ~clk19;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           tid;
        logic [W-1:0] dat;
        bit           ais;
    } exp_t;

    exp_t         sbq[$];
    int           txlog[$];
    logic [W-1:0] dlog[$];
    bit           alog[$];

    function automatic void chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: each trib holds at most one byte; the output stage holds one byte;
    // the next byte goes to the first waiting enabled trib cyclically after the last one served.
    logic [W-1:0] md [NT];
    bit           ma [NT];
    bit           mp [NT];
    bit           op [NT];
    bit           mo [NT];
    bit           mfull;
    int           mlast;

    always @(posedge clk19) begin
        if (!rst) begin
            for (int i = 0; i < NT; i++) begin
                md[i] = '0; ma[i] = 1'b0; mp[i] = 1'b0; mo[i] = 1'b0;
            end
            mfull = 1'b0;
            mlast = NT - 1;
            sbq.delete();
        end else begin
            int g;
            g  = -1;
            op = mp;
            if (!mfull || map_rdy) begin
                for (int k = 1; k <= NT; k++) begin
                    int c;
                    c = (mlast + k) % NT;
                    if (g < 0 && op[c] && trib_en[c]) g = c;
                end
            end
            if (g >= 0) begin
                sbq.push_back('{g, md[g], ma[g]});
                mfull = 1'b1;
                mlast = g;
            end else if (map_rdy) begin
                mfull = 1'b0;
            end
            for (int i = 0; i < NT; i++) begin
                if (!trib_en[i]) begin
                    mp[i] = 1'b0;
                end else if (rx_vld[i] && (!op[i] || g == i)) begin
                    mp[i] = 1'b1;
                    md[i] = (AISINS && rx_ais[i]) ? W'(8'hFF) : rx_dat[i*W +: W];
                    ma[i] = rx_ais[i];
                end else if (g == i) begin
                    mp[i] = 1'b0;
                end
                if (rx_vld[i] && trib_en[i] && op[i] && g != i) mo[i] = 1'b1;
                else if (ovf_clr[i]) mo[i] = 1'b0;
            end
        end
    end

    bit           pv = 1'b0;
    logic [W-1:0] p_dat;
    logic [TW-1:0] p_tid;
    logic         p_ais;

    always @(negedge clk19) begin
        if (!rst) begin
            pv = 1'b0;
        end else begin
            logic [NT-1:0] mov;
            for (int i = 0; i < NT; i++) mov[i] = mo[i];
            chk("ovf_vec", longint'(ovf), longint'(mov));
            chk("map_vld", longint'(map_vld), longint'(mfull));
            if (pv) begin
                chk("hold_dat", longint'(map_dat), longint'(p_dat));
                chk("hold_tid", longint'(map_tid), longint'(p_tid));
                chk("hold_ais", longint'(map_ais), longint'(p_ais));
            end
            if (map_vld && map_rdy) begin
                txlog.push_back(int'(map_tid));
                dlog.push_back(map_dat);
                alog.push_back(map_ais);
                if (sbq.size() == 0) begin
                    chk("unexpected_tx", longint'(map_tid), -1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("tx_tid", longint'(map_tid), longint'(e.tid));
                    chk("tx_dat", longint'(map_dat), longint'(e.dat));
                    chk("tx_ais", longint'(map_ais), longint'(e.ais));
                end
            end
            pv    = map_vld && !map_rdy;
            p_dat = map_dat;
            p_tid = map_tid;
            p_ais = map_ais;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk19);
            #1;
        end
    endtask

    task automatic strobe(int t, logic [W-1:0] d, logic a);
        rx_dat[t*W +: W] = d;
        rx_ais[t]        = a;
        rx_vld[t]        = 1'b1;
        tick(1);
        rx_vld = '0;
    endtask

    function automatic int count_tid(int t);
        int n;
        n = 0;
        foreach (txlog[k]) if (txlog[k] == t) n++;
        return n;
    endfunction

    initial begin
        trib_en = '1;
        rx_dat  = '0;
        rx_vld  = '0;
        rx_ais  = '0;
        map_rdy = 1'b0;
        ovf_clr = '0;
        tick(3);
        chk("rst_vld", longint'(map_vld), 0);
        chk("rst_dat", longint'(map_dat), 0);
        chk("rst_tid", longint'(map_tid), 0);
        chk("rst_ais", longint'(map_ais), 0);
        chk("rst_ovf", longint'(ovf), 0);
        rst = 1'b1;
        tick(2);

        // all tribs strobe together: served 0..NT-1 back to back
        map_rdy = 1'b1;
        txlog.delete();
        for (int i = 0; i < NT; i++) rx_dat[i*W +: W] = W'($urandom);
        rx_vld = '1;
        tick(1);
        rx_vld = '0;
        tick(NT + 6);
        chk("fair_cnt", longint'(txlog.size()), NT);
        for (int k = 0; k < NT; k++) chk("fair_order", longint'(txlog[k]), k);
        chk("fair_ovf", longint'(ovf), 0);

        // backpressure holds the presented byte
        map_rdy = 1'b0;
        strobe(3, 8'h5A, 1'b0);
        tick(1);
        for (int k = 0; k < 10; k++) begin
            chk("bp_vld", longint'(map_vld), 1);
            chk("bp_dat", longint'(map_dat), 8'h5A);
            chk("bp_tid", longint'(map_tid), 3);
            tick(1);
        end
        txlog.delete();
        map_rdy = 1'b1;
        tick(4);
        chk("bp_once", longint'(txlog.size()), 1);

        // overflow while the output stage is stalled
        map_rdy = 1'b0;
        strobe(2, 8'h77, 1'b0);
        tick(2);
        strobe(7, 8'h11, 1'b0);
        strobe(7, 8'h22, 1'b0);
        tick(1);
        chk("ovf7_set", longint'(ovf[7]), 1);
        txlog.delete();
        dlog.delete();
        map_rdy = 1'b1;
        tick(6);
        chk("ovf_tx_cnt", longint'(txlog.size()), 2);
        chk("ovf_tx_tid", longint'(count_tid(7)), 1);
        chk("ovf_tx_dat", longint'((dlog.size() > 1) ? dlog[1] : W'(0)), 8'h11);
        chk("ovf7_sticky", longint'(ovf[7]), 1);
        ovf_clr[7] = 1'b1;
        tick(1);
        ovf_clr = '0;
        chk("ovf7_clr", longint'(ovf[7]), 0);

        // disable drops a waiting byte and ignores later strobes
        map_rdy = 1'b0;
        strobe(1, 8'hAB, 1'b0);
        tick(2);
        strobe(4, 8'h44, 1'b0);
        trib_en[4] = 1'b0;
        tick(2);
        txlog.delete();
        map_rdy = 1'b1;
        tick(5);
        strobe(4, 8'h55, 1'b0);
        strobe(4, 8'h66, 1'b0);
        tick(5);
        chk("dis_none", longint'(count_tid(4)), 0);
        chk("dis_tx_cnt", longint'(txlog.size()), 1);
        chk("dis_ovf", longint'(ovf[4]), 0);
        trib_en[4] = 1'b1;

        // AIS tagging and optional substitution
        dlog.delete();
        alog.delete();
        strobe(9, 8'h3C, 1'b1);
        tick(4);
        rx_ais[9] = 1'b0;
        chk("ais_cnt", longint'(dlog.size()), 1);
        chk("ais_flag", longint'((alog.size() > 0) ? alog[0] : 1'b0), 1);
        chk("ais_dat", longint'((dlog.size() > 0) ? dlog[0] : W'(0)), AISINS ? 8'hFF : 8'h3C);

        // randomized traffic with stalls, live enables and clears
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NT; i++) begin
                rx_vld[i]        = ($urandom_range(0, 99) < 8);
                rx_dat[i*W +: W] = W'($urandom);
                if ($urandom_range(0, 99) < 3) rx_ais[i] = ~rx_ais[i];
                if ($urandom_range(0, 999) < 2) trib_en[i] = ~trib_en[i];
                ovf_clr[i]       = ($urandom_range(0, 99) < 2);
            end
            if ((c / 200) % 3 == 2) map_rdy = ($urandom_range(0, 9) == 0);
            else map_rdy = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        rx_vld  = '0;
        ovf_clr = '0;
        rx_ais  = '0;
        trib_en = '1;

        // async reset while a byte is presented
        map_rdy = 1'b0;
        tick(2);
        strobe(6, 8'h99, 1'b0);
        tick(2);
        chk("prerst_vld", longint'(map_vld), 1);
        rst = 1'b0;
        #1;
        chk("arst_vld", longint'(map_vld), 0);
        chk("arst_dat", longint'(map_dat), 0);
        chk("arst_tid", longint'(map_tid), 0);
        chk("arst_ais", longint'(map_ais), 0);
        chk("arst_ovf", longint'(ovf), 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        txlog.delete();
        map_rdy = 1'b1;
        rx_vld[5] = 1'b1;
        rx_vld[0] = 1'b1;
        tick(1);
        rx_vld = '0;
        tick(6);
        chk("arst_tx_cnt", longint'(txlog.size()), 2);
        chk("arst_first", longint'((txlog.size() > 0) ? txlog[0] : -1), 0);
        chk("arst_second", longint'((txlog.size() > 1) ? txlog[1] : -1), 5);

        tick(50);
        chk("sb_drained", longint'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
